// File: rtl/alu_seq_pkg.sv
// +----------------------------------------------------------------------+
// | Module  : alu_seq_pkg                                                |
// | Brief   : ALU function selects and state encoding for the sequencer  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

package alu_seq_pkg;

    localparam logic [4:0] FS_PASSA32 = 5'b10000;
    localparam logic [4:0] FS_ADD32   = 5'b10100;
    localparam logic [4:0] FS_SUB32   = 5'b10110;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADD  = 3'd1,
        S_DBL  = 3'd2,
        S_NEG  = 3'd3,
        S_DONE = 3'd4
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_multiply_sequencer.sv
// +----------------------------------------------------------------------+
// | Module  : alu_multiply_sequencer                                     |
// | Brief   : 16x16->32 shift-and-add multiply using the shared ALU      |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_multiply_sequencer
    import alu_seq_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Signed,
    input  logic [15:0] OpA,
    input  logic [15:0] OpB,
    input  logic [31:0] ALUOut,
    output logic [31:0] ALU_A,
    output logic [31:0] ALU_B,
    output logic [4:0]  ALU_FunSel,
    output logic        ALU_WF,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Product
);

    seq_state_t  state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        negf_q, negf_d;
    logic [31:0] product_q, product_d;

    // 0x8000 negates to itself, which is the correct unsigned magnitude.
    function automatic logic [15:0] mag16(input logic [15:0] v, input logic sgn);
        return (sgn && v[15]) ? (~v + 16'd1) : v;
    endfunction

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            negf_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            negf_q    <= negf_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        negf_d    = negf_q;
        product_d = product_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    mcand_d  = {16'h0000, mag16(OpA, Signed)};
                    mplier_d = mag16(OpB, Signed);
                    acc_d    = '0;
                    cnt_d    = '0;
                    negf_d   = Signed & (OpA[15] ^ OpB[15]);
                    state_d  = S_ADD;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_ADD: begin
                acc_d   = ALUOut;
                state_d = S_DBL;
            end
            S_DBL: begin
                mcand_d  = ALUOut;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 4'd1;
                // Terminate on the last count value, not on the wrap to zero.
                if (cnt_q == 4'd15) begin
                    if (negf_q) begin
                        state_d = S_NEG;
                    end else begin
                        state_d   = S_DONE;
                        product_d = acc_q;
                    end
                end else begin
                    state_d = S_ADD;
                end
            end
            S_NEG: begin
                acc_d     = ALUOut;
                product_d = ALUOut;
                state_d   = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ALU_A      = '0;
        ALU_B      = '0;
        ALU_FunSel = FS_PASSA32;
        ALU_WF     = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state_q)
            S_ADD: begin
                ALU_A      = acc_q;
                ALU_B      = mplier_q[0] ? mcand_q : 32'h0;
                ALU_FunSel = FS_ADD32;
                Busy       = 1'b1;
            end
            S_DBL: begin
                ALU_A      = mcand_q;
                ALU_B      = mcand_q;
                ALU_FunSel = FS_ADD32;
                Busy       = 1'b1;
            end
            S_NEG: begin
                ALU_B      = acc_q;
                ALU_FunSel = FS_SUB32;
                Busy       = 1'b1;
            end
            S_DONE: Done = 1'b1;
            default: ;
        endcase
    end

    assign Product = product_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_multiply_sequencer.sv
// +----------------------------------------------------------------------+
// | Module  : tb_alu_multiply_sequencer                                  |
// | Brief   : self-checking bench with an arithmetic reference model     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_alu_multiply_sequencer;

    logic        Clock = 1'b0;
    logic        Reset, Start, Signed;
    logic [15:0] OpA, OpB;
    logic [31:0] ALUOut, ALU_A, ALU_B, Product;
    logic [4:0]  ALU_FunSel;
    logic        ALU_WF, Busy, Done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [31:0] p;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    alu_multiply_sequencer dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Signed(Signed),
        .OpA(OpA), .OpB(OpB), .ALUOut(ALUOut),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FunSel(ALU_FunSel),
        .ALU_WF(ALU_WF), .Busy(Busy), .Done(Done), .Product(Product)
    );

    always #5 Clock = ~Clock;

    // Shared 32-bit ALU, only the functions the sequencer uses.
    always_comb begin
        case (ALU_FunSel)
            5'b10000: ALUOut = ALU_A;
            5'b10100: ALUOut = ALU_A + ALU_B;
            5'b10110: ALUOut = ALU_A - ALU_B;
            default:  ALUOut = 32'hDEAD_BEEF;
        endcase
    end

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            input logic s);
        longint x, y, r;
        x = s ? longint'($signed(a)) : longint'({16'h0, a});
        y = s ? longint'($signed(b)) : longint'({16'h0, b});
        r = x * y;
        return r[31:0];
    endfunction

    function automatic int ref_lat(input logic [15:0] a, input logic [15:0] b, input logic s);
        return (s && (a[15] ^ b[15])) ? 33 : 32;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_ctl"}, {27'h0, Busy, Done, ALU_WF, 2'b00} | {24'h0, 3'b000, ALU_FunSel},
            {24'h0, 3'b000, 5'b10000});
        chk({nm, "_product"}, Product, 32'h0);
        chk({nm, "_alu_a"}, ALU_A, 32'h0);
        chk({nm, "_alu_b"}, ALU_B, 32'h0);
    endtask

    // Launch one operation from the current cycle; optionally inject a
    // spurious Start after edge inj, or reset after edge rst_at.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input logic [31:0] ep, input int elat,
                          input int inj, input int rst_at);
        int   n;
        int   busy_n;
        logic seen_done;
        logic wf_seen;
        Start = 1'b1; OpA = a; OpB = b; Signed = s;
        @(posedge Clock); #1;
        Start = 1'b0;
        n = 0; busy_n = 0; seen_done = 1'b0; wf_seen = 1'b0;
        while (!seen_done && n < 40) begin
            if (Busy) busy_n++;
            if (ALU_WF) wf_seen = 1'b1;
            if (n == inj) begin
                Start = 1'b1; OpA = a ^ 16'h5A5A; OpB = b + 16'd3; Signed = ~s;
            end else if (n == inj + 1) begin
                Start = 1'b0;
            end
            if (n == rst_at) begin
                Reset = 1'b1;
                @(posedge Clock); #1;
                Reset = 1'b0;
                chk_reset_outputs("mid_reset");
                return;
            end
            @(posedge Clock); #1;
            n++;
            if (Done) seen_done = 1'b1;
        end
        chk("done_seen", {31'h0, seen_done}, 32'h1);
        chk("latency", n, elat);
        chk("busy_cycles", busy_n, elat);
        chk("product", Product, ep);
        chk("busy_in_done", {31'h0, Busy}, 32'h0);
        chk("wf_never", {31'h0, wf_seen}, 32'h0);
    endtask

    task automatic idle_check(input logic [31:0] ep);
        @(posedge Clock); #1;
        chk("idle_ctl", {27'h0, Busy, Done, ALU_FunSel[4:2]}, {27'h0, 2'b00, 3'b100});
        chk("idle_product_held", Product, ep);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        logic        rs;
        vecs[0] = '{16'h0003, 16'h0005, 1'b0, 32'h0000_000F, 32};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 32};
        vecs[2] = '{16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF_0001, 32};
        vecs[3] = '{16'hFFFD, 16'h0007, 1'b1, 32'hFFFF_FFEB, 33};
        vecs[4] = '{16'h8000, 16'h8000, 1'b1, 32'h4000_0000, 32};
        vecs[5] = '{16'h0000, 16'h1234, 1'b0, 32'h0000_0000, 32};
        vecs[6] = '{16'h0000, 16'hFFFF, 1'b1, 32'h0000_0000, 33};
        vecs[7] = '{16'hFFFF, 16'h0002, 1'b1, 32'hFFFF_FFFE, 33};

        Reset = 1'b1; Start = 1'b0; Signed = 1'b0; OpA = '0; OpB = '0;
        repeat (3) @(posedge Clock);
        #1;
        chk_reset_outputs("reset");
        Reset = 1'b0;
        @(posedge Clock); #1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].p, vecs[i].lat, -1, -1);
            if (i % 2 == 1) idle_check(vecs[i].p);
        end

        // Spurious Start mid-operation must be ignored.
        run_op(16'h0003, 16'h0005, 1'b0, 32'h0000_000F, 32, 9, -1);
        idle_check(32'h0000_000F);

        // Back-to-back: second Start issued in the DONE cycle.
        run_op(16'h1234, 16'h0010, 1'b0, 32'h0001_2340, 32, -1, -1);
        run_op(16'hFFFE, 16'h0003, 1'b1, 32'hFFFF_FFFA, 33, -1, -1);

        // Abort then rerun.
        run_op(16'd100, 16'd200, 1'b0, 32'h0, 32, -1, 12);
        run_op(16'd100, 16'd200, 1'b0, 32'h0000_4E20, 32, -1, -1);
        idle_check(32'h0000_4E20);

        for (int k = 0; k < 24; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            if (k == 3) ra = 16'h8000;
            if (k == 5) rb = 16'h0000;
            run_op(ra, rb, rs, ref_mul(ra, rb, rs), ref_lat(ra, rb, rs), -1, -1);
            if ($urandom_range(0, 1) == 1) idle_check(ref_mul(ra, rb, rs));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
